cpu_bus_sync_ctrl: RTL and testbench

Synchronous controller for the asynchronous CPU register interface. It synchronizes the CPU strobes (CS_, OE_, WR_) into the system clock domain and sequences each bus cycle through a small state machine. Writes commit into the three configuration registers exactly once per WR_ pulse. Reads present a stable registered snapshot. It sits between the top-level tri-state data bus and the register consumers, and replaces direct strobe-driven register writes.

---
 rtl/cpu_bus_sync_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cpu_bus_sync_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_sync_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_bus_sync_ctrl
//
// Purpose:
//   Brings the asynchronous CPU register strobes (CS_, OE_, WR_) into the clk
//   domain and sequences each bus cycle through a small FSM. A write commits
//   into reg1/reg2/reg3 exactly once per WR_ pulse. A read presents a
//   registered snapshot on data_out that never changes during the read.
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   CS_       in   async chip select, active low
//   OE_       in   async output enable, active low
//   WR_       in   async write strobe, active low
//   Addr      in   [7:0] CPU address
//   data_in   in   [7:0] data sampled from the tri-state data bus
//   data_out  out  [7:0] registered read data
//   data_oe   out  top level drives the data bus with data_out when 1
//   reg1..3   out  [7:0] configuration registers
//   wr_pulse  out  one-cycle strobe on a committed write to a mapped address
//   wr_miss   out  one-cycle strobe on a committed write to an unmapped address
//
// SYNC_STAGES has a legal range of 2..4.
// -----------------------------------------------------------------------------
module cpu_bus_sync_ctrl #(
    parameter logic [7:0] ADDR_REG1   = 8'h01,
    parameter logic [7:0] ADDR_REG2   = 8'h02,
    parameter logic [7:0] ADDR_REG3   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CS_,
    input  logic       OE_,
    input  logic       WR_,
    input  logic [7:0] Addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] reg3,
    output logic       wr_pulse,
    output logic       wr_miss
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_COMMIT = 2'd2,
        S_READ   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Strobe synchronizers. Bit 0 is the first flop, bit SYNC_STAGES-1 the
    // last. r_sync_vld tracks how far real input samples have propagated
    // since reset, so the reset value 1 in the chain is not mistaken for an
    // observed idle bus.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_oe_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;

    // Addr/data sampled on the same edge as the first synchronizer stage, so
    // a sample paired with r_wr_sync[0]==0 was taken while WR_ was low.
    logic [7:0] r_addr_smp;
    logic [7:0] r_data_smp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync  <= '1;
            r_oe_sync  <= '1;
            r_wr_sync  <= '1;
            r_sync_vld <= '0;
            r_addr_smp <= 8'h00;
            r_data_smp <= 8'h00;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], CS_};
            r_oe_sync  <= {r_oe_sync[SYNC_STAGES-2:0], OE_};
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], WR_};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_addr_smp <= Addr;
            r_data_smp <= data_in;
        end
    end

    logic w_s_cs;
    logic w_s_oe;
    logic w_s_wr;

    assign w_s_cs = r_cs_sync[SYNC_STAGES-1];
    assign w_s_oe = r_oe_sync[SYNC_STAGES-1];
    assign w_s_wr = r_wr_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Arm bit: a strobe that was already active when reset released must be
    // ignored, so no cycle is accepted until the bus has been seen fully idle.
    // -------------------------------------------------------------------------
    logic r_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm <= 1'b0;
        end else if (r_sync_vld[SYNC_STAGES-1] && w_s_cs && w_s_oe && w_s_wr) begin
            r_arm <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Bus-cycle FSM
    // -------------------------------------------------------------------------
    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                // Write wins when WR_ and OE_ are both active.
                if (r_arm && !w_s_cs) begin
                    if (!w_s_wr) begin
                        w_next = S_WRITE;
                    end else if (!w_s_oe) begin
                        w_next = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // WR_ release commits even if CS_ rose on the same edge;
                // CS_ rising while WR_ is still low aborts.
                if (w_s_wr) begin
                    w_next = S_COMMIT;
                end else if (w_s_cs) begin
                    w_next = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_next = S_IDLE;
            end
            S_READ: begin
                if (w_s_oe || w_s_cs) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Write hold registers. Captured on every edge that is in (or entering)
    // WRITE while the first sync stage still shows WR_ low, so the last
    // capture is always a sample taken with WR_ low and the CPU is free to
    // change Addr/data right after WR_ rises. r_hold_vld guards a pulse too
    // short to produce any capture: it then reaches COMMIT with nothing to
    // write and is dropped rather than writing stale data.
    // -------------------------------------------------------------------------
    logic [7:0] r_hold_addr;
    logic [7:0] r_hold_data;
    logic       r_hold_vld;
    logic       w_cap;

    assign w_cap = (w_next == S_WRITE) && !r_wr_sync[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_addr <= 8'h00;
            r_hold_data <= 8'h00;
            r_hold_vld  <= 1'b0;
        end else if (w_cap) begin
            r_hold_addr <= r_addr_smp;
            r_hold_data <= r_data_smp;
            r_hold_vld  <= 1'b1;
        end else if (r_state != S_WRITE) begin
            r_hold_vld  <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Commit: registers and strobes update on the edge entering COMMIT.
    // -------------------------------------------------------------------------
    logic       w_commit;
    logic       w_wr_hit;
    logic [7:0] r_reg1;
    logic [7:0] r_reg2;
    logic [7:0] r_reg3;
    logic       r_wr_pulse;
    logic       r_wr_miss;

    assign w_commit = (r_state == S_WRITE) && (w_next == S_COMMIT) && r_hold_vld;
    assign w_wr_hit = (r_hold_addr == ADDR_REG1) ||
                      (r_hold_addr == ADDR_REG2) ||
                      (r_hold_addr == ADDR_REG3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg1     <= 8'h00;
            r_reg2     <= 8'h00;
            r_reg3     <= 8'h00;
            r_wr_pulse <= 1'b0;
            r_wr_miss  <= 1'b0;
        end else begin
            r_wr_pulse <= w_commit && w_wr_hit;
            r_wr_miss  <= w_commit && !w_wr_hit;
            if (w_commit) begin
                if (r_hold_addr == ADDR_REG1) begin
                    r_reg1 <= r_hold_data;
                end else if (r_hold_addr == ADDR_REG2) begin
                    r_reg2 <= r_hold_data;
                end else if (r_hold_addr == ADDR_REG3) begin
                    r_reg3 <= r_hold_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: snapshot taken once on entry to READ, held afterwards.
    // -------------------------------------------------------------------------
    logic [7:0] w_rd_sel;
    logic [7:0] r_data_out;
    logic       r_data_oe;

    always_comb begin
        w_rd_sel = 8'h00;
        if (r_addr_smp == ADDR_REG1) begin
            w_rd_sel = r_reg1;
        end else if (r_addr_smp == ADDR_REG2) begin
            w_rd_sel = r_reg2;
        end else if (r_addr_smp == ADDR_REG3) begin
            w_rd_sel = r_reg3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else begin
            r_data_oe <= (w_next == S_READ);
            if ((r_state == S_IDLE) && (w_next == S_READ)) begin
                r_data_out <= w_rd_sel;
            end
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
    assign reg1     = r_reg1;
    assign reg2     = r_reg2;
    assign reg3     = r_reg3;
    assign wr_pulse = r_wr_pulse;
    assign wr_miss  = r_wr_miss;

endmodule

// File: tb/tb_cpu_bus_sync_ctrl.sv
module tb_cpu_bus_sync_ctrl;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       CS_ = 1'b1;
    logic       OE_ = 1'b1;
    logic       WR_ = 1'b1;
    logic [7:0] Addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] reg3;
    logic       wr_pulse;
    logic       wr_miss;

    int total = 0;
    int bad   = 0;

    // strobe/oe cycle counters, sampled mid-cycle
    int n_pulse = 0;
    int n_miss  = 0;
    int n_oe    = 0;

    // reference model: register file indexed 1..3 by mapped address
    logic [7:0] m_reg [1:3];

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_pulse;
        int         exp_miss;
    } vec_t;

    vec_t vecs [9];

    cpu_bus_sync_ctrl #(.SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .CS_      (CS_),
        .OE_      (OE_),
        .WR_      (WR_),
        .Addr     (Addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .reg1     (reg1),
        .reg2     (reg2),
        .reg3     (reg3),
        .wr_pulse (wr_pulse),
        .wr_miss  (wr_miss)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse) n_pulse++;
        if (wr_miss)  n_miss++;
        if (data_oe)  n_oe++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic int midx(input logic [7:0] a);
        case (a)
            8'h01:   return 1;
            8'h02:   return 2;
            8'h03:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (midx(a) == 0) return 8'h00;
        return m_reg[midx(a)];
    endfunction

    task automatic m_clear();
        for (int i = 1; i <= 3; i++) m_reg[i] = 8'h00;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_reg1"}, reg1, m_reg[1]);
        chk({tag, "_reg2"}, reg2, m_reg[2]);
        chk({tag, "_reg3"}, reg3, m_reg[3]);
    endtask

    // Full write cycle: CS_/WR_ low for lowc clocks, both rise together, bus
    // values scrambled right after the rise, then wait past commit.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input int lowc,
                             output int dp, output int dm);
        int p0;
        int m0;
        p0 = n_pulse;
        m0 = n_miss;
        Addr = a; data_in = d; CS_ = 1'b0; WR_ = 1'b0;
        repeat (lowc) tick();
        CS_ = 1'b1; WR_ = 1'b1;
        Addr = 8'($urandom); data_in = 8'($urandom);
        repeat (SS + 3) tick();
        dp = n_pulse - p0;
        dm = n_miss - m0;
        if (midx(a) != 0) m_reg[midx(a)] = d;
    endtask

    // Full read cycle with latency, stability and release checks.
    task automatic bus_read(input logic [7:0] a, input int holdc, input logic [7:0] want);
        int badc;
        badc = 0;
        Addr = a; CS_ = 1'b0; OE_ = 1'b0;
        tick(); tick();
        chk("rd_oe_early", data_oe, 1'b0);
        tick();
        chk("rd_oe_on", data_oe, 1'b1);
        chk("rd_data", data_out, want);
        repeat (holdc - 3) begin
            tick();
            if (data_oe !== 1'b1 || data_out !== want) badc++;
        end
        chk("rd_stable", badc, 0);
        OE_ = 1'b1; CS_ = 1'b1; Addr = 8'($urandom);
        tick(); tick();
        chk("rd_oe_hold", data_oe, 1'b1);
        tick();
        chk("rd_oe_off", data_oe, 1'b0);
        chk("rd_dout_keep", data_out, want);
        tick();
    endtask

    initial begin
        int dp;
        int dm;
        int p0;
        int m0;
        int o0;
        logic [7:0] a;
        logic [7:0] d;
        int lowc;

        vecs[0] = '{1'b1, 8'h01, 8'h11, 8'h00, 1, 0};
        vecs[1] = '{1'b1, 8'h02, 8'h22, 8'h00, 1, 0};
        vecs[2] = '{1'b1, 8'h03, 8'h33, 8'h00, 1, 0};
        vecs[3] = '{1'b0, 8'h01, 8'h00, 8'h11, 0, 0};
        vecs[4] = '{1'b0, 8'h02, 8'h00, 8'h22, 0, 0};
        vecs[5] = '{1'b0, 8'h03, 8'h00, 8'h33, 0, 0};
        vecs[6] = '{1'b1, 8'h7F, 8'h5A, 8'h00, 0, 1};
        vecs[7] = '{1'b0, 8'h7F, 8'h00, 8'h00, 0, 0};
        vecs[8] = '{1'b0, 8'h03, 8'h00, 8'h33, 0, 0};

        m_clear();

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_dout", data_out, 8'h00);
        chk("rst_oe", data_oe, 1'b0);
        chk("rst_pulse", wr_pulse, 1'b0);
        chk("rst_miss", wr_miss, 1'b0);
        chk_regs("rst");
        rst = 1'b0;
        repeat (4) tick();

        // write latency: A5 -> 02, commit on the 3rd edge after WR_ rise
        p0 = n_pulse;
        Addr = 8'h02; data_in = 8'hA5; CS_ = 1'b0; WR_ = 1'b0;
        repeat (6) tick();
        CS_ = 1'b1; WR_ = 1'b1; Addr = 8'hFF; data_in = 8'h00;
        tick(); tick();
        chk("wlat_e2_reg2", reg2, 8'h00);
        chk("wlat_e2_pulse", wr_pulse, 1'b0);
        tick();
        chk("wlat_e3_reg2", reg2, 8'hA5);
        chk("wlat_e3_pulse", wr_pulse, 1'b1);
        tick();
        chk("wlat_e4_pulse", wr_pulse, 1'b0);
        repeat (2) tick();
        m_reg[2] = 8'hA5;
        chk("wlat_pulse_cnt", n_pulse - p0, 1);
        chk_regs("wlat");

        // table-driven write/read vectors
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data, 6, dp, dm);
                chk($sformatf("vec%0d_pulse", i), dp, vecs[i].exp_pulse);
                chk($sformatf("vec%0d_miss", i), dm, vecs[i].exp_miss);
                chk_regs($sformatf("vec%0d", i));
            end else begin
                bus_read(vecs[i].addr, 10, vecs[i].exp_rd);
            end
        end

        // abort: CS_ rises while WR_ stays low 4 more clocks
        p0 = n_pulse; m0 = n_miss;
        Addr = 8'h01; data_in = 8'hEE; CS_ = 1'b0; WR_ = 1'b0;
        repeat (6) tick();
        CS_ = 1'b1;
        repeat (4) tick();
        WR_ = 1'b1;
        repeat (6) tick();
        chk("abort_pulse", n_pulse - p0, 0);
        chk("abort_miss", n_miss - m0, 0);
        chk_regs("abort");

        // CS_ and WR_ rising together commits
        bus_write(8'h01, 8'h44, 5, dp, dm);
        chk("csrise_pulse", dp, 1);
        chk_regs("csrise");

        // WR_ and OE_ together: write wins, no read
        o0 = n_oe;
        Addr = 8'h01; data_in = 8'h3C; CS_ = 1'b0; WR_ = 1'b0; OE_ = 1'b0;
        repeat (6) tick();
        CS_ = 1'b1; WR_ = 1'b1; OE_ = 1'b1;
        repeat (6) tick();
        m_reg[1] = 8'h3C;
        chk("both_oe_cycles", n_oe - o0, 0);
        chk_regs("both");

        // reset mid-WRITE, WR_ still low after release: no commit
        Addr = 8'h03; data_in = 8'h99; CS_ = 1'b0; WR_ = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_clear();
        p0 = n_pulse; m0 = n_miss;
        repeat (5) tick();
        WR_ = 1'b1; CS_ = 1'b1;
        repeat (6) tick();
        chk("rstw_pulse", n_pulse - p0, 0);
        chk("rstw_miss", n_miss - m0, 0);
        chk_regs("rstw");
        bus_write(8'h02, 8'h5C, 6, dp, dm);
        chk("rstw_next_pulse", dp, 1);
        chk_regs("rstw_next");

        // reset mid-READ drops data_oe on the next edge
        Addr = 8'h02; CS_ = 1'b0; OE_ = 1'b0;
        repeat (5) tick();
        chk("rstr_oe_before", data_oe, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstr_oe_after", data_oe, 1'b0);
        rst = 1'b0;
        m_clear();
        CS_ = 1'b1; OE_ = 1'b1;
        repeat (5) tick();

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       a = 8'h01;
                1:       a = 8'h02;
                2:       a = 8'h03;
                default: a = 8'($urandom);
            endcase
            d = 8'($urandom);
            lowc = $urandom_range(SS + 2, 8);
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, d, lowc, dp, dm);
                chk($sformatf("rnd%0d_pulse", k), dp, (midx(a) != 0) ? 1 : 0);
                chk($sformatf("rnd%0d_miss", k), dm, (midx(a) == 0) ? 1 : 0);
                chk_regs($sformatf("rnd%0d", k));
            end else begin
                bus_read(a, lowc, m_read(a));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
